// File: rtl/mem_stage3_banked_if.sv
// Request bus into the memory stage-3 block.
// The upstream stage drives the request fields (master); the memory stage
// returns in_ready (slave).
//   in_valid/in_ready      : handshake, accept when both are high
//   mem_read/mem_write     : operation type (at most one set)
//   hit/addr_valid         : cache lookup result
//   mem_addr               : row address (low bits index the banks)
//   write_data/write_mask  : per-lane store data and enables
//   thread_mask/word_offset, warp_id, scb_id, reg_addr, instr : metadata
//   miss_latency           : cycles until miss feedback
interface mem_stage3_banked_if #(
    parameter int NUM_LANES = 8,
    parameter int DATA_W    = 32,
    parameter int LAT_W     = 5,
    parameter int WARP_W    = 3,
    parameter int SCB_W     = 2
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          mem_read;
    logic                          mem_write;
    logic                          hit;
    logic                          addr_valid;
    logic [26:0]                   mem_addr;
    logic [NUM_LANES*DATA_W-1:0]   write_data;
    logic [NUM_LANES-1:0]          write_mask;
    logic [NUM_LANES-1:0]          thread_mask;
    logic [3*NUM_LANES-1:0]        word_offset;
    logic [WARP_W-1:0]             warp_id;
    logic [SCB_W-1:0]              scb_id;
    logic [4:0]                    reg_addr;
    logic [31:0]                   instr;
    logic [LAT_W-1:0]              miss_latency;

    modport master (
        output in_valid, mem_read, mem_write, hit, addr_valid, mem_addr,
               write_data, write_mask, thread_mask, word_offset, warp_id,
               scb_id, reg_addr, instr, miss_latency,
        input  in_ready
    );

    modport slave (
        input  in_valid, mem_read, mem_write, hit, addr_valid, mem_addr,
               write_data, write_mask, thread_mask, word_offset, warp_id,
               scb_id, reg_addr, instr, miss_latency,
        output in_ready
    );
endinterface

// File: rtl/mem_stage3_banked.sv
// GPU memory stage 3: lane-banked data memory with per-lane write masking,
// an independent host (FIO) port, and an in-order latency-counting MSHR
// queue for misses.
//   clk, reset        : clock, asynchronous active-high reset
//   req               : request bus (slave side), in_ready = MSHR not full
//   fio_*             : host port, full-row write, 1-cycle registered read
//   reg_write_o, write_fb_valid_o, read_data_o, *_o metadata :
//                       hit results, two cycles after acceptance
//   nfb_*             : one-cycle miss-feedback pulse with miss info
//   mshr_count_o      : MSHR occupancy
module mem_stage3_banked #(
    parameter int NUM_LANES  = 8,
    parameter int DATA_W     = 32,
    parameter int MEM_DEPTH  = 512,
    parameter int MSHR_DEPTH = 4,
    parameter int LAT_W      = 5,
    parameter int WARP_W     = 3,
    parameter int SCB_W      = 2,
    localparam int ADDR_W    = $clog2(MEM_DEPTH),
    localparam int ROW_W     = NUM_LANES * DATA_W,
    localparam int PTR_W     = $clog2(MSHR_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    mem_stage3_banked_if.slave       req,
    input  logic                     fio_we,
    input  logic [ADDR_W-1:0]        fio_addr,
    input  logic [ROW_W-1:0]         fio_wdata,
    output logic [ROW_W-1:0]         fio_rdata,
    output logic                     reg_write_o,
    output logic                     write_fb_valid_o,
    output logic [ROW_W-1:0]         read_data_o,
    output logic [WARP_W-1:0]        warp_id_o,
    output logic [SCB_W-1:0]         scb_id_o,
    output logic [4:0]               reg_addr_o,
    output logic [NUM_LANES-1:0]     thread_mask_o,
    output logic [3*NUM_LANES-1:0]   word_offset_o,
    output logic [31:0]              instr_o,
    output logic                     nfb_valid_o,
    output logic [26:0]              nfb_addr_o,
    output logic [WARP_W-1:0]        nfb_warp_id_o,
    output logic [SCB_W-1:0]         nfb_scb_id_o,
    output logic [CNT_W-1:0]         mshr_count_o
);
    localparam int META_W = WARP_W + SCB_W + 5 + NUM_LANES + 3*NUM_LANES + 32;

    logic [ROW_W-1:0] mem_q [MEM_DEPTH];

    logic accept, hit_acc, miss_push, retire;
    logic [META_W-1:0] meta_in;

    // Stage 0: accepted hit request, bank access happens at the next edge.
    logic              s0_valid, s0_read, s0_write;
    logic [ADDR_W-1:0] s0_addr;
    logic [ROW_W-1:0]  s0_wdata;
    logic [NUM_LANES-1:0] s0_wmask;
    logic [META_W-1:0] s0_meta;
    // Stage 1: bank read data registered.
    logic              s1_valid, s1_read, s1_write;
    logic [META_W-1:0] s1_meta;
    logic [ROW_W-1:0]  s1_rdata;
    logic [META_W-1:0] meta_o_q;

    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [MSHR_DEPTH-1:0] mshr_vld_q;
    logic [LAT_W-1:0]      mshr_cnt_q  [MSHR_DEPTH];
    logic [26:0]           mshr_addr_q [MSHR_DEPTH];
    logic [WARP_W-1:0]     mshr_warp_q [MSHR_DEPTH];
    logic [SCB_W-1:0]      mshr_scb_q  [MSHR_DEPTH];

    assign req.in_ready = (mshr_count_o < CNT_W'(MSHR_DEPTH));
    assign accept       = req.in_valid && req.in_ready;
    assign hit_acc      = req.hit || !req.addr_valid;
    assign miss_push    = accept && req.addr_valid && !req.hit;
    // The head's count reaches zero at this edge (or already has), so its
    // feedback pulse is registered now and the entry pops at the same edge.
    assign retire       = mshr_vld_q[rd_ptr_q] && (mshr_cnt_q[rd_ptr_q] <= LAT_W'(1));

    assign meta_in = {req.warp_id, req.scb_id, req.reg_addr, req.thread_mask,
                      req.word_offset, req.instr};
    assign {warp_id_o, scb_id_o, reg_addr_o, thread_mask_o, word_offset_o, instr_o} = meta_o_q;

    // Bank array: host write first so a same-row port-A lane write overrides it.
    always_ff @(posedge clk) begin
        if (fio_we)
            mem_q[fio_addr] <= fio_wdata;
        if (s0_valid && s0_write) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (s0_wmask[i])
                    mem_q[s0_addr][i*DATA_W +: DATA_W] <= s0_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_valid         <= 1'b0;
            s0_read          <= 1'b0;
            s0_write         <= 1'b0;
            s0_addr          <= '0;
            s0_wdata         <= '0;
            s0_wmask         <= '0;
            s0_meta          <= '0;
            s1_valid         <= 1'b0;
            s1_read          <= 1'b0;
            s1_write         <= 1'b0;
            s1_meta          <= '0;
            s1_rdata         <= '0;
            reg_write_o      <= 1'b0;
            write_fb_valid_o <= 1'b0;
            read_data_o      <= '0;
            meta_o_q         <= '0;
            fio_rdata        <= '0;
        end else begin
            s0_valid         <= accept && hit_acc;
            s0_read          <= req.mem_read;
            s0_write         <= req.mem_write;
            s0_addr          <= req.mem_addr[ADDR_W-1:0];
            s0_wdata         <= req.write_data;
            s0_wmask         <= req.write_mask;
            s0_meta          <= meta_in;
            s1_valid         <= s0_valid;
            s1_read          <= s0_read;
            s1_write         <= s0_write;
            s1_meta          <= s0_meta;
            s1_rdata         <= mem_q[s0_addr];
            reg_write_o      <= s1_valid && s1_read;
            write_fb_valid_o <= s1_valid && s1_write;
            read_data_o      <= (s1_valid && s1_read) ? s1_rdata : '0;
            if (s1_valid)
                meta_o_q <= s1_meta;
            fio_rdata        <= mem_q[fio_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (miss_push) begin
            mshr_addr_q[wr_ptr_q] <= req.mem_addr;
            mshr_warp_q[wr_ptr_q] <= req.warp_id;
            mshr_scb_q[wr_ptr_q]  <= req.scb_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mshr_vld_q    <= '0;
            mshr_count_o  <= '0;
            for (int i = 0; i < MSHR_DEPTH; i++)
                mshr_cnt_q[i] <= '0;
            nfb_valid_o   <= 1'b0;
            nfb_addr_o    <= '0;
            nfb_warp_id_o <= '0;
            nfb_scb_id_o  <= '0;
        end else begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                if (mshr_vld_q[i] && mshr_cnt_q[i] != '0)
                    mshr_cnt_q[i] <= mshr_cnt_q[i] - LAT_W'(1);
            end
            nfb_valid_o <= retire;
            if (retire) begin
                mshr_vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q             <= rd_ptr_q + PTR_W'(1);
                nfb_addr_o           <= mshr_addr_q[rd_ptr_q];
                nfb_warp_id_o        <= mshr_warp_q[rd_ptr_q];
                nfb_scb_id_o         <= mshr_scb_q[rd_ptr_q];
            end
            // Push only happens when not full, so it never lands on the head slot.
            if (miss_push) begin
                mshr_vld_q[wr_ptr_q] <= 1'b1;
                mshr_cnt_q[wr_ptr_q] <= (req.miss_latency == '0) ? LAT_W'(1) : req.miss_latency;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            case ({miss_push, retire})
                2'b10:   mshr_count_o <= mshr_count_o + CNT_W'(1);
                2'b01:   mshr_count_o <= mshr_count_o - CNT_W'(1);
                default: mshr_count_o <= mshr_count_o;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage3_banked.sv
module tb_mem_stage3_banked;
    localparam int NUM_LANES = 8;
    localparam int DATA_W    = 32;
    localparam int ROW_W     = NUM_LANES * DATA_W;
    localparam int LAT_W     = 5;
    localparam int WARP_W    = 3;
    localparam int SCB_W     = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_stage3_banked_if #(.NUM_LANES(NUM_LANES), .DATA_W(DATA_W), .LAT_W(LAT_W),
                           .WARP_W(WARP_W), .SCB_W(SCB_W)) req ();

    logic                   fio_we;
    logic [8:0]             fio_addr;
    logic [ROW_W-1:0]       fio_wdata, fio_rdata, read_data_o;
    logic                   reg_write_o, write_fb_valid_o, nfb_valid_o;
    logic [WARP_W-1:0]      warp_id_o, nfb_warp_id_o;
    logic [SCB_W-1:0]       scb_id_o, nfb_scb_id_o;
    logic [4:0]             reg_addr_o;
    logic [NUM_LANES-1:0]   thread_mask_o;
    logic [3*NUM_LANES-1:0] word_offset_o;
    logic [31:0]            instr_o;
    logic [26:0]            nfb_addr_o;
    logic [2:0]             mshr_count_o;

    mem_stage3_banked dut (
        .clk(clk), .reset(reset), .req(req),
        .fio_we(fio_we), .fio_addr(fio_addr), .fio_wdata(fio_wdata), .fio_rdata(fio_rdata),
        .reg_write_o(reg_write_o), .write_fb_valid_o(write_fb_valid_o), .read_data_o(read_data_o),
        .warp_id_o(warp_id_o), .scb_id_o(scb_id_o), .reg_addr_o(reg_addr_o),
        .thread_mask_o(thread_mask_o), .word_offset_o(word_offset_o), .instr_o(instr_o),
        .nfb_valid_o(nfb_valid_o), .nfb_addr_o(nfb_addr_o), .nfb_warp_id_o(nfb_warp_id_o),
        .nfb_scb_id_o(nfb_scb_id_o), .mshr_count_o(mshr_count_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic h, input logic av,
                         input logic [26:0] a, input logic [WARP_W-1:0] w,
                         input logic [SCB_W-1:0] s, input logic [LAT_W-1:0] lat);
        req.in_valid     = 1'b1;
        req.mem_read     = rd;
        req.mem_write    = wr;
        req.hit          = h;
        req.addr_valid   = av;
        req.mem_addr     = a;
        req.warp_id      = w;
        req.scb_id       = s;
        req.miss_latency = lat;
    endtask

    logic [ROW_W-1:0] row5, row5_new, wdata_aa;
    int pulses;

    initial begin
        req.in_valid = 0; req.mem_read = 0; req.mem_write = 0; req.hit = 0;
        req.addr_valid = 0; req.mem_addr = '0; req.write_data = '0; req.write_mask = '0;
        req.thread_mask = '0; req.word_offset = '0; req.warp_id = '0; req.scb_id = '0;
        req.reg_addr = '0; req.instr = '0; req.miss_latency = '0;
        fio_we = 0; fio_addr = '0; fio_wdata = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            row5[i*DATA_W +: DATA_W]     = DATA_W'(i);
            row5_new[i*DATA_W +: DATA_W] = (i < 4) ? 32'hAA : DATA_W'(i);
            wdata_aa[i*DATA_W +: DATA_W] = 32'hAA;
        end

        #2 reset = 1'b1;
        #1;
        chk("rst_in_ready", 256'(req.in_ready), 256'(1));
        chk("rst_count", 256'(mshr_count_o), 256'(0));
        chk("rst_outs", 256'({reg_write_o, write_fb_valid_o, nfb_valid_o}), 256'(0));
        chk("rst_rdata", 256'(read_data_o), 256'(0));
        chk("rst_fio_rdata", 256'(fio_rdata), 256'(0));
        tick; tick;
        reset = 1'b0;
        tick;

        // Host fills row 5 with lane index values.
        fio_we = 1; fio_addr = 9'd5; fio_wdata = row5;
        tick;
        fio_we = 0;
        tick;
        chk("fio_read_row5", 256'(fio_rdata), 256'(row5));

        // Hit read of row 5: strobe exactly two edges after acceptance.
        drive(1, 0, 1, 1, 27'd5, 3'd3, 2'd2, 5'd0);
        req.instr = 32'hDEADBEEF; req.reg_addr = 5'd17; req.thread_mask = 8'hF0;
        tick;
        req.in_valid = 0;
        tick;
        chk("hit_rd_t1_strobe", 256'(reg_write_o), 256'(0));
        tick;
        chk("hit_rd_strobe", 256'(reg_write_o), 256'(1));
        chk("hit_rd_data", 256'(read_data_o), 256'(row5));
        chk("hit_rd_meta", 256'({warp_id_o, scb_id_o, reg_addr_o, thread_mask_o, instr_o}),
            256'({3'd3, 2'd2, 5'd17, 8'hF0, 32'hDEADBEEF}));
        tick;
        chk("hit_rd_single", 256'(reg_write_o), 256'(0));

        // Masked hit write of row 5, lanes 0-3 only.
        drive(0, 1, 1, 1, 27'd5, 3'd1, 2'd0, 5'd0);
        req.write_data = wdata_aa; req.write_mask = 8'h0F;
        tick;
        req.in_valid = 0; req.write_mask = '0;
        tick; tick;
        chk("hit_wr_fb", 256'({write_fb_valid_o, reg_write_o}), 256'(2'b10));
        chk("hit_wr_rdata_zero", 256'(read_data_o), 256'(0));
        tick;
        chk("hit_wr_fb_single", 256'(write_fb_valid_o), 256'(0));

        // Read back through the "not addr_valid" path, which counts as a hit.
        drive(1, 0, 0, 0, 27'd5, 3'd4, 2'd0, 5'd0);
        tick;
        req.in_valid = 0;
        tick; tick;
        chk("rd_after_wr_strobe", 256'(reg_write_o), 256'(1));
        chk("rd_after_wr_data", 256'(read_data_o), 256'(row5_new));

        // Single miss, L=3.
        drive(1, 0, 0, 1, 27'h123, 3'd2, 2'd1, 5'd3);
        tick;
        req.in_valid = 0;
        chk("miss_count", 256'(mshr_count_o), 256'(1));
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            tick;
            chk($sformatf("miss_nfb_k%0d", k), 256'(nfb_valid_o), 256'(k == 3));
            if (k == 3)
                chk("miss_nfb_info", 256'({nfb_addr_o, nfb_warp_id_o, nfb_scb_id_o}),
                    256'({27'h123, 3'd2, 2'd1}));
            if (reg_write_o) pulses++;
        end
        chk("miss_no_reg_write", 256'(pulses), 256'(0));

        // In-order retire: A (L=10) then B (L=0).
        drive(1, 0, 0, 1, 27'h0A0, 3'd4, 2'd0, 5'd10);
        tick;
        drive(1, 0, 0, 1, 27'h0B0, 3'd5, 2'd3, 5'd0);
        for (int k = 1; k <= 13; k++) begin
            tick;
            if (k == 1) req.in_valid = 0;
            chk($sformatf("order_nfb_k%0d", k), 256'(nfb_valid_o), 256'(k == 10 || k == 11));
            chk($sformatf("order_cnt_k%0d", k), 256'(mshr_count_o),
                256'((k < 10) ? 2 : (k == 10) ? 1 : 0));
            if (k == 10) chk("order_a_warp", 256'(nfb_warp_id_o), 256'(4));
            if (k == 11) chk("order_b_warp", 256'({nfb_warp_id_o, nfb_scb_id_o}), 256'({3'd5, 2'd3}));
        end

        // Fill the MSHR, then hold a fifth request until space frees.
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1, 27'(16 + i), 3'(i), 2'd0, 5'd5);
            tick;
        end
        chk("full_in_ready", 256'(req.in_ready), 256'(0));
        chk("full_count", 256'(mshr_count_o), 256'(4));
        drive(1, 0, 0, 1, 27'h1F0, 3'd7, 2'd2, 5'd5);
        for (int k = 4; k <= 14; k++) begin
            tick;
            if (k == 4) chk("full_hold_ready", 256'(req.in_ready), 256'(0));
            if (k == 5) chk("full_free_ready_cnt", 256'({req.in_ready, mshr_count_o}), 256'({1'b1, 3'd3}));
            if (k == 6) begin
                chk("full_push_retire_cnt", 256'(mshr_count_o), 256'(3));
                req.in_valid = 0;
            end
            if (k == 11) chk("fifth_nfb", 256'({nfb_valid_o, nfb_warp_id_o, nfb_addr_o}),
                             256'({1'b1, 3'd7, 27'h1F0}));
            if (k == 12) chk("drained_count", 256'(mshr_count_o), 256'(0));
        end

        // Reset with two misses and one hit in flight.
        drive(1, 0, 0, 1, 27'h55, 3'd1, 2'd1, 5'd4);
        tick;
        drive(1, 0, 0, 1, 27'h56, 3'd2, 2'd1, 5'd4);
        tick;
        drive(1, 0, 1, 1, 27'd5, 3'd6, 2'd3, 5'd0);
        tick;
        req.in_valid = 0;
        chk("pre_rst_count", 256'(mshr_count_o), 256'(2));
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_count", 256'({req.in_ready, mshr_count_o}), 256'({1'b1, 3'd0}));
        chk("mid_rst_outs", 256'({reg_write_o, write_fb_valid_o, nfb_valid_o, warp_id_o, instr_o}), 256'(0));
        chk("mid_rst_rdata", 256'(read_data_o), 256'(0));
        tick;
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            tick;
            if (reg_write_o || write_fb_valid_o || nfb_valid_o) pulses++;
        end
        chk("post_rst_no_pulses", 256'(pulses), 256'(0));
        chk("post_rst_count", 256'(mshr_count_o), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
